// File: rtl/fs_rate_pkg.sv
// Shared definitions for the fs_en rate monitor: lock state encoding,
// counter widths and the no-wrap absolute-difference helper.
package fs_rate_pkg;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2,
      ST_HOLD     = 2'd3
   } lock_state_e;

   localparam int unsigned CNT_W  = 32;   // window, strobe and gap counters
   localparam int unsigned DIFF_W = 33;   // expected count is 2*baud, needs one extra bit
   localparam int unsigned HM_W   = 4;    // hit / miss counters

   // |a - b| without wrap-around
   function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                  input logic [DIFF_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/fs_gap_detect.sv
// Strobe-loss detector: counts fs_en-free cycles, saturating at GAP_MAX,
// and registers strobe_lost while the count sits at saturation.
// Ports:
//   sys_clk, glb_rst_n : clock, async active-low reset
//   fs_en              : strobe input
//   strobe_lost        : high while GAP_MAX strobe-free cycles have elapsed
module fs_gap_detect
   import fs_rate_pkg::*;
#(
   parameter int unsigned GAP_MAX = 32'd1000
) (
   input  logic sys_clk,
   input  logic glb_rst_n,
   input  logic fs_en,
   output logic strobe_lost
);

   localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_MAX);

   logic [CNT_W-1:0] gap_cnt;

   // gap counter and its registered saturation flag
   always_ff @(posedge sys_clk or negedge glb_rst_n) begin
      if (!glb_rst_n) begin
         gap_cnt     <= '0;
         strobe_lost <= 1'b0;
      end else begin
         strobe_lost <= (gap_cnt == GAP_LIM);
         if (fs_en) begin
            gap_cnt <= '0;
         end else if (gap_cnt != GAP_LIM) begin
            gap_cnt <= gap_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/fs_rate_monitor.sv
// fs_en rate monitor: counts strobes over a GATE_CYCLES window, compares the
// count against 2*SYS_Baud_Num within TOL, and runs a lock FSM with
// hysteresis plus strobe-loss forcing.
// Ports:
//   sys_clk, glb_rst_n : clock, async active-low reset
//   fs_en              : single-cycle strobe input
//   SYS_Baud_Num       : expected baud number (expected count = 2x)
//   meas_num           : strobe count of last completed window
//   meas_valid         : one-cycle pulse when meas_num updates
//   rate_lock          : high in LOCKED and HOLD
//   strobe_lost        : no strobe for GAP_MAX cycles
//   state_o            : current lock state
module fs_rate_monitor
   import fs_rate_pkg::*;
#(
   parameter int unsigned GATE_CYCLES = 32'd10000,
   parameter int unsigned TOL         = 32'd2,
   parameter int unsigned LOCK_CNT    = 3,
   parameter int unsigned UNLOCK_CNT  = 2,
   parameter int unsigned GAP_MAX     = 32'd1000
) (
   input  logic        sys_clk,
   input  logic        glb_rst_n,
   input  logic        fs_en,
   input  logic [31:0] SYS_Baud_Num,
   output logic [31:0] meas_num,
   output logic        meas_valid,
   output logic        rate_lock,
   output logic        strobe_lost,
   output logic [1:0]  state_o
);

   localparam logic [CNT_W-1:0]  WIN_LAST = CNT_W'(GATE_CYCLES - 1);
   localparam logic [DIFF_W-1:0] TOL_D    = DIFF_W'(TOL);
   localparam logic [HM_W-1:0]   LOCK_N   = HM_W'(LOCK_CNT);
   localparam logic [HM_W-1:0]   UNLOCK_N = HM_W'(UNLOCK_CNT);

   logic [CNT_W-1:0]  win_cnt;
   logic [CNT_W-1:0]  strb_cnt;
   logic [DIFF_W-1:0] exp_q;
   logic [DIFF_W-1:0] exp_q_prev;
   logic [DIFF_W-1:0] exp_in_c;
   logic              win_first_c;
   logic              win_last_c;
   logic              match_c;

   lock_state_e       state_q, state_d;
   logic [HM_W-1:0]   hit_q, hit_d;
   logic [HM_W-1:0]   miss_q, miss_d;

   assign win_first_c = (win_cnt == '0);
   assign win_last_c  = (win_cnt == WIN_LAST);
   assign exp_in_c    = {SYS_Baud_Num, 1'b0};
   assign match_c     = (abs_diff({1'b0, meas_num}, exp_q_prev) <= TOL_D);

   fs_gap_detect #(
      .GAP_MAX     (GAP_MAX)
   ) u_gap_detect (
      .sys_clk     (sys_clk),
      .glb_rst_n   (glb_rst_n),
      .fs_en       (fs_en),
      .strobe_lost (strobe_lost)
   );

   // Gate window, strobe accumulation and expected-count latching.
   // With a one-cycle window the first and last cycle coincide, so the
   // judged expectation is taken straight from the input in that case.
   always_ff @(posedge sys_clk or negedge glb_rst_n) begin
      if (!glb_rst_n) begin
         win_cnt    <= '0;
         strb_cnt   <= '0;
         meas_num   <= '0;
         meas_valid <= 1'b0;
         exp_q      <= '0;
         exp_q_prev <= '0;
      end else begin
         meas_valid <= win_last_c;
         if (win_first_c) begin
            exp_q <= exp_in_c;
         end
         if (win_last_c) begin
            win_cnt    <= '0;
            strb_cnt   <= '0;
            meas_num   <= strb_cnt + CNT_W'(fs_en);
            exp_q_prev <= win_first_c ? exp_in_c : exp_q;
         end else begin
            win_cnt  <= win_cnt + CNT_W'(1);
            strb_cnt <= strb_cnt + CNT_W'(fs_en);
         end
      end
   end

   // Lock FSM next state; strobe loss overrides any window evaluation
   always_comb begin
      state_d = state_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      if (strobe_lost) begin
         state_d = ST_UNLOCKED;
         hit_d   = '0;
         miss_d  = '0;
      end else if (meas_valid) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (match_c) begin
                  hit_d = HM_W'(1);
                  if (LOCK_N == HM_W'(1)) state_d = ST_LOCKED;
                  else                    state_d = ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (match_c) begin
                  hit_d = hit_q + HM_W'(1);
                  if (hit_d == LOCK_N) state_d = ST_LOCKED;
               end else begin
                  hit_d   = '0;
                  state_d = ST_UNLOCKED;
               end
            end
            ST_LOCKED: begin
               if (!match_c) begin
                  miss_d = HM_W'(1);
                  if (UNLOCK_N == HM_W'(1)) state_d = ST_UNLOCKED;
                  else                      state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (match_c) begin
                  miss_d  = '0;
                  state_d = ST_LOCKED;
               end else begin
                  miss_d = miss_q + HM_W'(1);
                  if (miss_d == UNLOCK_N) state_d = ST_UNLOCKED;
               end
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end
   end

   // Lock FSM state register; rate_lock follows the registered state
   always_ff @(posedge sys_clk or negedge glb_rst_n) begin
      if (!glb_rst_n) begin
         state_q   <= ST_UNLOCKED;
         hit_q     <= '0;
         miss_q    <= '0;
         rate_lock <= 1'b0;
      end else begin
         state_q   <= state_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         rate_lock <= (state_d == ST_LOCKED) || (state_d == ST_HOLD);
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_fs_rate_monitor.sv
// Bench for fs_rate_monitor: a window-level behavioural model checked every
// cycle against two instances (1000-cycle window and 1-cycle window), plus
// directed scenario checks with hand-computed values.
module tb_fs_rate_monitor;

   localparam int G    = 1000;
   localparam int GAPM = 100;

   logic        sys_clk = 1'b0;
   logic        glb_rst_n = 1'b0;
   logic        fs_en = 1'b0;
   logic [31:0] baud = 32'd250;
   logic [31:0] baud1 = 32'd0;

   logic [31:0] meas_num, s1_meas_num;
   logic        meas_valid, rate_lock, strobe_lost;
   logic        s1_meas_valid, s1_rate_lock, s1_strobe_lost;
   logic [1:0]  state_o, s1_state_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 0;
   int rate_n  = 500;
   bit silent  = 0;
   int drv_pos = 0;

   always #5 sys_clk = ~sys_clk;

   fs_rate_monitor #(
      .GATE_CYCLES(G), .TOL(2), .LOCK_CNT(3), .UNLOCK_CNT(2), .GAP_MAX(GAPM)
   ) u_dut (
      .sys_clk(sys_clk), .glb_rst_n(glb_rst_n), .fs_en(fs_en), .SYS_Baud_Num(baud),
      .meas_num(meas_num), .meas_valid(meas_valid), .rate_lock(rate_lock),
      .strobe_lost(strobe_lost), .state_o(state_o)
   );

   fs_rate_monitor #(
      .GATE_CYCLES(1), .TOL(0), .LOCK_CNT(1), .UNLOCK_CNT(1), .GAP_MAX(4)
   ) u_dut1 (
      .sys_clk(sys_clk), .glb_rst_n(glb_rst_n), .fs_en(fs_en), .SYS_Baud_Num(baud1),
      .meas_num(s1_meas_num), .meas_valid(s1_meas_valid), .rate_lock(s1_rate_lock),
      .strobe_lost(s1_strobe_lost), .state_o(s1_state_o)
   );

   // ---------------- behavioural model ----------------
   longint m_g[2]     = '{1000, 1};
   longint m_tol[2]   = '{2, 0};
   longint m_lockc[2] = '{3, 1};
   longint m_unl[2]   = '{2, 1};
   longint m_gapm[2]  = '{100, 4};

   longint mp_pos[2], mp_cnt[2], mp_wexp[2], mp_meas[2], mp_evexp[2], mp_gap[2];
   bit     mp_valid[2], mp_lost[2], mp_locked[2];
   longint mp_streak[2], mp_misses[2];

   task automatic model_reset(input int i);
      mp_pos[i] = 0; mp_cnt[i] = 0; mp_wexp[i] = 0; mp_meas[i] = 0; mp_evexp[i] = 0;
      mp_gap[i] = 0; mp_valid[i] = 0; mp_lost[i] = 0; mp_locked[i] = 0;
      mp_streak[i] = 0; mp_misses[i] = 0;
   endtask

   task automatic model_step(input int i, input bit fs, input logic [31:0] b);
      longint d;
      bit ok;
      // lock decision on the window reported in the previous cycle
      if (mp_lost[i]) begin
         mp_locked[i] = 0; mp_streak[i] = 0; mp_misses[i] = 0;
      end else if (mp_valid[i]) begin
         d = mp_meas[i] - mp_evexp[i];
         if (d < 0) d = -d;
         ok = (d <= m_tol[i]);
         if (!mp_locked[i]) begin
            if (ok) begin
               mp_streak[i]++;
               if (mp_streak[i] >= m_lockc[i]) begin mp_locked[i] = 1; mp_misses[i] = 0; end
            end else mp_streak[i] = 0;
         end else begin
            if (ok) mp_misses[i] = 0;
            else begin
               mp_misses[i]++;
               if (mp_misses[i] >= m_unl[i]) begin mp_locked[i] = 0; mp_streak[i] = 0; end
            end
         end
      end
      mp_lost[i] = (mp_gap[i] == m_gapm[i]);
      if (fs) mp_gap[i] = 0;
      else if (mp_gap[i] < m_gapm[i]) mp_gap[i]++;
      if (mp_pos[i] == 0) mp_wexp[i] = 2 * longint'(b);
      if (mp_pos[i] == m_g[i] - 1) begin
         mp_meas[i] = mp_cnt[i] + longint'(fs); mp_valid[i] = 1; mp_evexp[i] = mp_wexp[i];
         mp_cnt[i] = 0; mp_pos[i] = 0;
      end else begin
         mp_cnt[i] += longint'(fs); mp_pos[i]++; mp_valid[i] = 0;
      end
   endtask

   function automatic logic [36:0] model_vec(input int i);
      logic [1:0] st;
      if (mp_locked[i]) st = (mp_misses[i] > 0) ? 2'd3 : 2'd2;
      else              st = (mp_streak[i] > 0) ? 2'd1 : 2'd0;
      return {32'(mp_meas[i]), mp_valid[i], mp_locked[i], mp_lost[i], st};
   endfunction

   always @(posedge sys_clk or negedge glb_rst_n) begin
      if (!glb_rst_n) begin
         for (int i = 0; i < 2; i++) model_reset(i);
      end else begin
         model_step(0, fs_en, baud);
         model_step(1, fs_en, baud1);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge sys_clk) begin
      if (cmp_en) begin
         check("inst0 {meas,valid,lock,lost,state}",
               64'({meas_num, meas_valid, rate_lock, strobe_lost, state_o}), 64'(model_vec(0)));
         check("inst1 {meas,valid,lock,lost,state}",
               64'({s1_meas_num, s1_meas_valid, s1_rate_lock, s1_strobe_lost, s1_state_o}),
               64'(model_vec(1)));
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic gen(input int p);
      if (silent) return 1'b0;
      return ((((p + 1) * rate_n) / G) != ((p * rate_n) / G));
   endfunction

   task automatic tick();
      @(posedge sys_clk);
      #1;
      drv_pos = (drv_pos + 1 == G) ? 0 : drv_pos + 1;
      fs_en = gen(drv_pos);
   endtask

   task automatic release_rst();
      @(posedge sys_clk);
      #1;
      glb_rst_n = 1'b1;
      drv_pos = 0;
      fs_en = gen(0);
   endtask

   task automatic wait_valid(input string name, output int n);
      bit found;
      found = 0;
      n = 0;
      while (!found && n < G + 5) begin
         tick();
         n++;
         found = (meas_valid === 1'b1);
      end
      check({name, " meas_valid seen"}, 64'(found), 64'd1);
   endtask

   task automatic window(input string name, input int exp_n, input int exp_meas,
                         input int next_rate, input int prev_st, input int exp_st,
                         input bit exp_lock);
      int n;
      wait_valid(name, n);
      if (exp_n >= 0) check({name, " valid cycle"}, 64'(n + 1), 64'(exp_n + 1));
      check({name, " meas_num"}, 64'(meas_num), 64'(exp_meas));
      check({name, " state at valid"}, 64'(state_o), 64'(prev_st));
      rate_n = next_rate;
      tick();
      check({name, " state"}, 64'(state_o), 64'(exp_st));
      check({name, " rate_lock"}, 64'(rate_lock), 64'(exp_lock));
   endtask

   task automatic check_all_zero(input string name);
      check({name, " meas_num"}, 64'(meas_num), 64'd0);
      check({name, " meas_valid"}, 64'(meas_valid), 64'd0);
      check({name, " rate_lock"}, 64'(rate_lock), 64'd0);
      check({name, " strobe_lost"}, 64'(strobe_lost), 64'd0);
      check({name, " state_o"}, 64'(state_o), 64'd0);
   endtask

   initial begin
      int t, m;
      repeat (3) @(posedge sys_clk);
      #1;
      cmp_en = 1;
      check_all_zero("reset");
      release_rst();

      // nominal lock, then hysteresis
      window("w1 nominal", G, 500, 500, 0, 1, 0);
      window("w2 nominal", -1, 500, 500, 1, 1, 0);
      window("w3 nominal", -1, 500, 400, 1, 2, 1);
      window("w4 hyst low", -1, 400, 500, 2, 3, 1);
      window("w5 hyst back", -1, 500, 400, 3, 2, 1);
      window("w6 hyst low", -1, 400, 400, 2, 3, 1);
      window("w7 hyst low2", -1, 400, 502, 3, 0, 0);
      // tolerance edge
      window("w8 tol 502", -1, 502, 503, 0, 1, 0);
      window("w9 tol 503", -1, 503, 500, 1, 0, 0);
      // relock
      window("w10 relock", -1, 500, 500, 0, 1, 0);
      window("w11 relock", -1, 500, 500, 1, 1, 0);
      window("w12 relock", -1, 500, 500, 1, 2, 1);

      // strobe loss from position 2 of the window
      silent = 1;
      t = 0;
      while (strobe_lost !== 1'b1 && t < 200) begin tick(); t++; end
      check("loss rise cycles", 64'(t), 64'(GAPM + 2));
      tick();
      check("loss state_o", 64'(state_o), 64'd0);
      check("loss rate_lock", 64'(rate_lock), 64'd0);
      while (drv_pos < 150) tick();
      silent = 0;
      tick();
      m = 0;
      while (strobe_lost === 1'b1 && m < 10) begin tick(); m++; end
      check("loss fall cycles", 64'(m), 64'd2);
      window("w13 loss", -1, 426, 500, 0, 0, 0);
      window("w14 relock", -1, 500, 500, 0, 1, 0);
      window("w15 relock", -1, 500, 500, 1, 1, 0);
      window("w16 relock", -1, 500, 500, 1, 2, 1);

      // mid-window baud change
      while (drv_pos < 500) tick();
      baud = 32'd125;
      window("w17 midchange", -1, 500, 500, 2, 2, 1);
      window("w18 after change", -1, 500, 500, 2, 3, 1);
      baud = 32'd250;

      // async reset mid-window
      while (drv_pos < 600) tick();
      glb_rst_n = 1'b0;
      #1;
      check_all_zero("mid reset");
      release_rst();
      window("w20 after reset", G, 500, 500, 0, 1, 0);
      window("w21 after reset", -1, 500, 500, 1, 1, 0);

      @(negedge sys_clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before 1000000");
      $fatal(1, "bench timeout");
   end

endmodule
